sram_mem_responder: RTL and testbench
=====================================

Name: sram_mem_responder

Overview:
- Memory-stage responder for the load/store requests the ID-stage control unit issues (mem_r_en / mem_w_en, carried down the pipeline).
- Serves each 32-bit word request against an external 16-bit single-port SRAM, as two half-word accesses with programmable wait cycles.
- Drops ready for the duration so the pipeline freezes, and returns the load data with a single-cycle ready pulse.

Parameters:
- ADDR_OFFSET, 1024: byte base of data memory; subtracted from the request address.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- HALF_CYCLES, 2: cycles per half-word access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- mem_r_en  in  1  load request; held stable until ready=1.
- mem_w_en  in  1  store request; held stable until ready=1.
- address  in  32  byte address from the ALU; bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data.
- ready  out  1  0 = pipeline must freeze; 1 = request complete or no request.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  drive enable for the SRAM data bus.
- sram_dq_in  in  16  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Address mapping:
  - word = (address - ADDR_OFFSET) >> 2, computed mod 2^32.
  - Low half at {word, 1'b0}, high half at {word, 1'b1}, truncated to SRAM_ADDR_W.
  - No range check.
- States and transitions:
  - IDLE -> LO on (mem_r_en | mem_w_en); otherwise stays in IDLE.
  - LO -> HI after HALF_CYCLES cycles in LO.
  - HI -> DONE after HALF_CYCLES cycles in HI.
  - DONE -> IDLE unconditionally.
  - A 4-bit counter times each phase and clears on every phase change.
- Inputs are sampled in IDLE only. Inputs are ignored in LO, HI and DONE; the request must stay stable while ready=0.
- If mem_r_en and mem_w_en are both high, the request is treated as a write.
- ready is combinational:
  - 1 when state=DONE.
  - 1 when state=IDLE with no request.
  - 0 otherwise.
  - Forced to 1 while rst_n=0.
- Latency: request seen in IDLE at cycle 0; ready=0 for cycles 0..2*HALF_CYCLES; ready=1 at cycle 2*HALF_CYCLES+1 (DONE). With the default HALF_CYCLES=2, ready stays low for 5 cycles.
- Write:
  - In LO: sram_dq_oe=1, sram_we_n=0, sram_dq_out=wdata[15:0].
  - In HI: sram_dq_oe=1, sram_we_n=0, sram_dq_out=wdata[31:16].
  - wdata is latched at request acceptance.
- Read:
  - sram_we_n=1 and sram_dq_oe=0 throughout.
  - sram_dq_in is captured into rdata[15:0] on the last LO cycle and into rdata[31:16] on the last HI cycle.
- rdata: valid from DONE and held until the next completed read. Writes never alter rdata.
- Outside LO/HI:
  - sram_we_n=1, sram_dq_oe=0.
  - sram_addr holds its last value.
  - sram_dq_out=0.
- A new request present in the DONE cycle is not accepted. It is accepted in the following IDLE cycle, because the pipeline advances on the DONE ready.
- Reset values: state=IDLE, counter=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Reset during LO/HI aborts the access. A partially written word is permitted. No further strobes are issued after the reset edge.

Optional Feature:
- Macro: SRAM_READ_BYPASS_EN.
- Defined:
  - Adds a one-entry buffer holding the tag (word address), the data and a valid bit.
  - A read in IDLE whose word matches a valid tag completes with zero latency: ready=1 that cycle, rdata=buffer data, no SRAM access, state stays IDLE.
  - Every completed read loads the buffer.
  - A write to the tagged word updates the buffer data.
  - Reset clears valid.
- Undefined: every read takes full latency; no extra state.

Test Plan:
- Write then read: write address=1024, wdata=0xDEADBEEF -> sram_addr 0 then 1; dq_out 0xBEEF then 0xDEAD; we_n low for 2 cycles each; ready low 5 cycles. Read of 1024 with SRAM model -> rdata=0xDEADBEEF at DONE.
- Address mapping: read of 1032 -> sram_addr 4 then 5. Read of 1020 -> word wraps to 0x3FFFFFFF; sram_addr = 0x3FFFE then 0x3FFFF.
- Idle pass-through: no request for 10 cycles -> ready=1 throughout, we_n=1, dq_oe=0, rdata unchanged.
- Back-to-back: store is held through DONE, then a read is issued the next cycle -> two separate 6-cycle transactions; the store is not repeated.
- Reset mid-write: rst_n=0 during LO cycle 2 -> next cycle we_n=1, dq_oe=0, ready=1, rdata=0. Request after release -> full latency.
- With SRAM_READ_BYPASS_EN: read 1024 twice -> second read has ready=1 immediately and no sram_addr activity. Write 0x12345678 to 1024, then read -> 0x12345678 with zero latency.

Source files
------------

// File: rtl/sram_mem_responder_if.sv
// rtl/sram_mem_responder_if.sv - pipeline load/store request bus between the memory stage and the SRAM responder
interface sram_mem_responder_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - serves 32-bit load/store requests as two half-word accesses on a 16-bit SRAM
// Optional one-entry read bypass buffer enabled by defining SRAM_READ_BYPASS_EN.
module sram_mem_responder #(
  parameter int unsigned ADDR_OFFSET = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_mem_responder_if.slave    bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(HALF_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        is_write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        request;
  logic        accept;
  logic        phase_end;
  logic        hit;
  logic        ready_c;
  logic        drive;

  logic [29:0]            req_word;
  logic [30:0]            lo_full;
  logic [SRAM_ADDR_W-1:0] lo_addr;

  assign req_word = 30'((bus.address - 32'(ADDR_OFFSET)) >> 2);
  assign lo_full  = {req_word, 1'b0};
  assign lo_addr  = SRAM_ADDR_W'(lo_full);
  assign request  = bus.mem_r_en | bus.mem_w_en;
  assign phase_end = (cnt == LAST_CNT);

`ifdef SRAM_READ_BYPASS_EN
  logic [29:0] byp_tag;
  logic [31:0] byp_data;
  logic        byp_valid;
  logic [29:0] pend_word;

  // A hit is a pure read; a write to the same word always goes to the SRAM.
  assign hit = (state == IDLE) && bus.mem_r_en && !bus.mem_w_en
               && byp_valid && (byp_tag == req_word);
  assign bus.rdata = hit ? byp_data : rdata_q;
`else
  assign hit = 1'b0;
  assign bus.rdata = rdata_q;
`endif

  assign bus.ready = ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      if (state != next_state)
        cnt <= 4'd0;
      else if (state == LO || state == HI)
        cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ready_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = !request || hit;
        if (request && !hit) begin
          next_state = LO;
          accept     = 1'b1;
        end
      end
      LO:      if (phase_end) next_state = HI;
      HI:      if (phase_end) next_state = DONE;
      DONE: begin
        ready_c    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!rst_n)
      ready_c = 1'b1;
  end

  // Strobes decode from the state register so a reset edge ends them immediately.
  always_comb begin
    drive       = is_write_q && (state == LO || state == HI);
    sram_we_n   = !drive;
    sram_dq_oe  = drive;
    sram_dq_out = 16'd0;
    if (drive)
      sram_dq_out = (state == LO) ? wdata_q[15:0] : wdata_q[31:16];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_write_q <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      sram_addr  <= '0;
`ifdef SRAM_READ_BYPASS_EN
      byp_valid  <= 1'b0;
      byp_tag    <= 30'd0;
      byp_data   <= 32'd0;
      pend_word  <= 30'd0;
`endif
    end else begin
      if (accept) begin
        is_write_q <= bus.mem_w_en;
        wdata_q    <= bus.wdata;
        sram_addr  <= lo_addr;
`ifdef SRAM_READ_BYPASS_EN
        pend_word  <= req_word;
        if (bus.mem_w_en && byp_valid && byp_tag == req_word)
          byp_data <= bus.wdata;
`endif
      end
      if (state == LO && phase_end) begin
        sram_addr <= {sram_addr[SRAM_ADDR_W-1:1], 1'b1};
        if (!is_write_q)
          rdata_q[15:0] <= sram_dq_in;
      end
      if (state == HI && phase_end && !is_write_q) begin
        rdata_q[31:16] <= sram_dq_in;
`ifdef SRAM_READ_BYPASS_EN
        byp_valid <= 1'b1;
        byp_tag   <= pend_word;
        byp_data  <= {sram_dq_in, rdata_q[15:0]};
`endif
      end
`ifdef SRAM_READ_BYPASS_EN
      if (hit)
        rdata_q <= byp_data;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb/tb_sram_mem_responder.sv - scoreboard bench for sram_mem_responder with a behavioural 16-bit SRAM
module tb_sram_mem_responder;
  localparam int HC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_mem_responder_if bus();

  sram_mem_responder #(
    .ADDR_OFFSET(1024),
    .SRAM_ADDR_W(18),
    .HALF_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [0:262143];
  logic        pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en)
      sram[pre_addr] <= pre_data;
    else if (!sram_we_n && sram_dq_oe)
      sram[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = sram[sram_addr];

  typedef struct {
    logic        ready;
    logic        we_n;
    logic        oe;
    logic [15:0] dq;
    logic [17:0] addr;
    bit          chk_addr;
    logic [31:0] rdata;
    bit          chk_rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_rdata;
  logic [17:0] hold_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] lo_of(input logic [31:0] a);
    return 18'(((a - 32'd1024) >> 2) << 1);
  endfunction

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rexp, input string nm);
    exp_t        e;
    logic [17:0] lo;
    lo = lo_of(a);
    for (int c = 0; c <= 2*HC+1; c++) begin
      e.ready = (c == 2*HC+1);
      e.we_n = 1'b1; e.oe = 1'b0; e.dq = 16'd0;
      e.chk_addr = (c >= 1); e.chk_rdata = (c == 2*HC+1);
      e.addr = (c <= HC) ? lo : (lo | 18'd1);
      e.rdata = wr ? cur_rdata : rexp;
      if (wr && c >= 1 && c <= 2*HC) begin
        e.we_n = 1'b0; e.oe = 1'b1;
        e.dq = (c <= HC) ? d[15:0] : d[31:16];
      end
      exp_q.push_back(e);
    end
    bus.mem_r_en = rd; bus.mem_w_en = wr; bus.address = a; bus.wdata = d;
    for (int c = 0; c <= 2*HC+1; c++) begin
      #1;
      e = exp_q.pop_front();
      chk($sformatf("%s c%0d ready", nm, c), 32'(bus.ready), 32'(e.ready));
      chk($sformatf("%s c%0d we_n", nm, c), 32'(sram_we_n), 32'(e.we_n));
      chk($sformatf("%s c%0d oe", nm, c), 32'(sram_dq_oe), 32'(e.oe));
      chk($sformatf("%s c%0d dq", nm, c), 32'(sram_dq_out), 32'(e.dq));
      if (e.chk_addr)
        chk($sformatf("%s c%0d addr", nm, c), 32'(sram_addr), 32'(e.addr));
      if (e.chk_rdata)
        chk($sformatf("%s c%0d rdata", nm, c), bus.rdata, e.rdata);
      @(posedge clk); @(negedge clk);
    end
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    if (!wr) cur_rdata = rexp;
    hold_addr = lo | 18'd1;
  endtask

`ifdef SRAM_READ_BYPASS_EN
  task automatic hit_read(input logic [31:0] a, input logic [31:0] rexp, input string nm);
    bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.address = a;
    #1;
    chk({nm, " ready"}, 32'(bus.ready), 32'd1);
    chk({nm, " rdata"}, bus.rdata, rexp);
    chk({nm, " we_n"}, 32'(sram_we_n), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.mem_r_en = 1'b0;
    #1;
    chk({nm, " addr still"}, 32'(sram_addr), 32'(hold_addr));
    chk({nm, " idle ready"}, 32'(bus.ready), 32'd1);
    chk({nm, " rdata held"}, bus.rdata, rexp);
    @(posedge clk); @(negedge clk);
    cur_rdata = rexp;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.address = 32'd0; bus.wdata = 32'd0;
    pre_en = 1'b0; pre_addr = 18'd0; pre_data = 16'd0;
    cur_rdata = 32'd0; hold_addr = 18'd0;
    @(negedge clk);
    preload(18'd4, 16'h5555);
    preload(18'd5, 16'hAAAA);
    preload(18'h3FFFE, 16'h1234);
    preload(18'h3FFFF, 16'hCDEF);
    #1;
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset we_n", 32'(sram_we_n), 32'd1);
    chk("reset oe", 32'(sram_dq_oe), 32'd0);
    chk("reset dq", 32'(sram_dq_out), 32'd0);
    chk("reset addr", 32'(sram_addr), 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, "wr1024");
    txn(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, "rd1024");
    txn(1'b1, 1'b0, 32'd1032, 32'd0, 32'hAAAA5555, "rd1032");
    txn(1'b1, 1'b0, 32'd1020, 32'd0, 32'hCDEF1234, "rd1020");

    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle%0d ready", i), 32'(bus.ready), 32'd1);
      chk($sformatf("idle%0d we_n", i), 32'(sram_we_n), 32'd1);
      chk($sformatf("idle%0d oe", i), 32'(sram_dq_oe), 32'd0);
      chk($sformatf("idle%0d rdata", i), bus.rdata, cur_rdata);
      @(posedge clk); @(negedge clk);
    end

    txn(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 32'd0, "b2b_wr");
    txn(1'b1, 1'b0, 32'd1032, 32'd0, 32'hAAAA5555, "b2b_rd");
    txn(1'b1, 1'b0, 32'd1036, 32'd0, 32'hCAFEF00D, "rd1036");
    txn(1'b1, 1'b1, 32'd1044, 32'h11112222, 32'd0, "both_wr");
    txn(1'b1, 1'b0, 32'd1044, 32'd0, 32'h11112222, "rd1044");

    bus.mem_w_en = 1'b1; bus.address = 32'd1040; bus.wdata = 32'h76543210;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_lo ready forced", 32'(bus.ready), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.mem_w_en = 1'b0;
    #1;
    chk("rst_after we_n", 32'(sram_we_n), 32'd1);
    chk("rst_after oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_after ready", 32'(bus.ready), 32'd1);
    chk("rst_after rdata", bus.rdata, 32'd0);
    chk("rst_after addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_rdata = 32'd0;
    txn(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 32'd0, "post_rst_wr");
    txn(1'b1, 1'b0, 32'd1040, 32'd0, 32'h0BADF00D, "post_rst_rd");

`ifdef SRAM_READ_BYPASS_EN
    txn(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, "byp_miss");
    hit_read(32'd1024, 32'hDEADBEEF, "byp_hit1");
    txn(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'd0, "byp_wr");
    hit_read(32'd1024, 32'h12345678, "byp_hit2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
